// File: rtl/load_store_watch_pkg.sv
// Shared types and default widths for the load/store full-flag watchdog.
//
// Contents:
//   PER_W_DEF, CNT_W_DEF : default period-timer and event-counter widths
//   state_e              : watchdog FSM state (2 bits, encoding 3 unused)
package load_store_watch_pkg;

  localparam int unsigned PER_W_DEF = 17;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StAlarm = 2'd2
  } state_e;

endpackage

// File: rtl/load_store_watch_if.sv
// Signal bundle between the load/store watchdog and its user.
// Optional feature macro: LOAD_STORE_WATCH_MINPER_EN adds short_per.
//
// Signals:
//   sig_in     : registered full flag from the load/store stage
//   alarm_clr  : one-cycle pulse clearing sticky alarm flags
//   full_cnt   : saturating count of full events
//   period     : last measured distance between full events (cycles)
//   period_vld : one-cycle pulse when period updates
//   timeout    : sticky "no full event within timeout" alarm
//   state      : FSM state, for debug
//   short_per  : sticky "period below minimum" flag (optional)
//
// Modports: master drives the inputs (user side), slave is the watchdog.
interface load_store_watch_if
  import load_store_watch_pkg::*;
#(
  parameter int unsigned PER_W = PER_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             sig_in;
  logic             alarm_clr;
  logic [CNT_W-1:0] full_cnt;
  logic [PER_W-1:0] period;
  logic             period_vld;
  logic             timeout;
  logic [1:0]       state;
`ifdef LOAD_STORE_WATCH_MINPER_EN
  logic             short_per;

  modport master (
    output sig_in, alarm_clr,
    input  full_cnt, period, period_vld, timeout, state, short_per
  );

  modport slave (
    input  sig_in, alarm_clr,
    output full_cnt, period, period_vld, timeout, state, short_per
  );
`else
  modport master (
    output sig_in, alarm_clr,
    input  full_cnt, period, period_vld, timeout, state
  );

  modport slave (
    input  sig_in, alarm_clr,
    output full_cnt, period, period_vld, timeout, state
  );
`endif

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector for a single-bit level.
//
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   d     : level input
//   rise  : combinational pulse, high when d is 1 and was 0 last cycle
//
// The history register resets to 0, so a level already high on the first
// cycle after reset is reported as a rise.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic sig_d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_d_q <= 1'b0;
    end else begin
      sig_d_q <= d;
    end
  end

  assign rise = d & ~sig_d_q;

endmodule

// File: rtl/load_store_watch.sv
// Liveness monitor for the load/store volume controller's full flag.
// Counts rising edges of sig_in ("full events"), measures the cycle distance
// between consecutive events and raises a sticky alarm if no event arrives
// within TIMEOUT cycles of the previous one.
// Optional feature macro: LOAD_STORE_WATCH_MINPER_EN adds a sticky short_per
// flag for periods shorter than MIN_PER.
//
// Ports:
//   clk    : clock, all state on posedge
//   rst_n  : synchronous active-low reset
//   bus_io : load_store_watch_if.slave (sig_in, alarm_clr in; full_cnt,
//            period, period_vld, timeout, state[, short_per] out)
//
// TIMEOUT must not exceed 2**PER_W-1. All outputs are registered.
module load_store_watch
  import load_store_watch_pkg::*;
#(
  parameter int unsigned PER_W   = PER_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = 60000,
  parameter int unsigned MIN_PER = 1000
) (
  input logic               clk,
  input logic               rst_n,
  load_store_watch_if.slave bus_io
);

  localparam logic [PER_W-1:0] TimeoutVal = PER_W'(TIMEOUT);
  localparam logic [PER_W-1:0] TimerOne   = PER_W'(1);

  logic rise;

  rise_detect u_rise_detect (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus_io.sig_in),
    .rise (rise)
  );

  state_e           state_q, state_d;
  logic [PER_W-1:0] timer_q, timer_d;
  logic [PER_W-1:0] timer_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             timeout_q, timeout_d;
  logic             alarm_set;
  logic             armed_rise;

  // Timer saturates instead of wrapping; only matters while parked in alarm.
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TimerOne;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    period_d   = period_q;
    vld_d      = 1'b0;
    alarm_set  = 1'b0;
    armed_rise = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (rise) begin
          state_d = StArmed;
          timer_d = TimerOne;
        end
      end
      StArmed: begin
        // A rise on the timeout cycle wins over the alarm.
        if (rise) begin
          timer_d    = TimerOne;
          period_d   = timer_q;
          vld_d      = 1'b1;
          armed_rise = 1'b1;
        end else begin
          timer_d = timer_inc;
          if (timer_q == TimeoutVal) begin
            state_d   = StAlarm;
            alarm_set = 1'b1;
          end
        end
      end
      StAlarm: begin
        // Measurement overflowed: re-arm without reporting a period.
        if (rise) begin
          state_d = StArmed;
          timer_d = TimerOne;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_comb begin
    timeout_d = timeout_q;
    if (alarm_set) begin
      timeout_d = 1'b1;
    end else if (bus_io.alarm_clr) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      vld_q     <= vld_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef LOAD_STORE_WATCH_MINPER_EN
  localparam logic [PER_W-1:0] MinPerVal = PER_W'(MIN_PER);

  logic short_q, short_d;

  always_comb begin
    short_d = short_q;
    if (armed_rise && (timer_q < MinPerVal)) begin
      short_d = 1'b1;
    end else if (bus_io.alarm_clr) begin
      short_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      short_q <= 1'b0;
    end else begin
      short_q <= short_d;
    end
  end

  assign bus_io.short_per = short_q;
`else
  logic unused_min_per;
  logic unused_armed_rise;
  assign unused_min_per    = ^MIN_PER;
  assign unused_armed_rise = armed_rise;
`endif

  assign bus_io.full_cnt   = cnt_q;
  assign bus_io.period     = period_q;
  assign bus_io.period_vld = vld_q;
  assign bus_io.timeout    = timeout_q;
  assign bus_io.state      = state_q;

endmodule

// File: tb/tb_load_store_watch.sv
// Self-checking bench for load_store_watch: a hand-built vector table,
// directed corner-case sequences and randomized traffic, all compared against
// an event-distance model (cycle index of the last rise, alarm flag).
module tb_load_store_watch;

  localparam int PerW   = 17;
  localparam int CntW   = 4;
  localparam int Tmo    = 100;
  localparam int MinPer = 10;
  localparam int CntMax = 15;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_store_watch_if #(.PER_W(PerW), .CNT_W(CntW)) bus ();

  load_store_watch #(
    .PER_W  (PerW),
    .CNT_W  (CntW),
    .TIMEOUT(Tmo),
    .MIN_PER(MinPer)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int vld_seen = 0;

  // Reference model state
  int cyc;
  int last_rise;
  bit alarmed;
  bit prev_sig;
  int m_cnt;
  int m_per;
  bit m_vld;
  bit m_to;
  bit m_short;

  typedef struct {
    bit         sig;
    bit         clr;
    logic [1:0] st;
    int         cnt;
    int         per;
    bit         vld;
    bit         to;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc       = 0;
    last_rise = -1;
    alarmed   = 1'b0;
    prev_sig  = 1'b0;
    m_cnt     = 0;
    m_per     = 0;
    m_vld     = 1'b0;
    m_to      = 1'b0;
    m_short   = 1'b0;
  endtask

  task automatic model_step(input bit sig, input bit clr);
    bit rise;
    bit set_to;
    bit set_short;
    rise      = sig & ~prev_sig;
    prev_sig  = sig;
    m_vld     = 1'b0;
    set_to    = 1'b0;
    set_short = 1'b0;
    if (rise) begin
      if (m_cnt < CntMax) m_cnt++;
      if (last_rise >= 0 && !alarmed) begin
        m_per = cyc - last_rise;
        m_vld = 1'b1;
        if (m_per < MinPer) set_short = 1'b1;
      end
      alarmed   = 1'b0;
      last_rise = cyc;
    end else if (last_rise >= 0 && !alarmed && (cyc - last_rise) == Tmo) begin
      alarmed = 1'b1;
      set_to  = 1'b1;
    end
    if (set_to) m_to = 1'b1;
    else if (clr) m_to = 1'b0;
    if (set_short) m_short = 1'b1;
    else if (clr) m_short = 1'b0;
    cyc++;
  endtask

  function automatic logic [31:0] m_state();
    if (last_rise < 0) return 32'd0;
    if (alarmed) return 32'd2;
    return 32'd1;
  endfunction

  task automatic compare_all();
    check("state", 32'(bus.state), m_state());
    check("full_cnt", 32'(bus.full_cnt), 32'(m_cnt));
    check("period", 32'(bus.period), 32'(m_per));
    check("period_vld", 32'(bus.period_vld), 32'(m_vld));
    check("timeout", 32'(bus.timeout), 32'(m_to));
`ifdef LOAD_STORE_WATCH_MINPER_EN
    check("short_per", 32'(bus.short_per), 32'(m_short));
`endif
  endtask

  task automatic drive(input bit sig, input bit clr);
    bus.sig_in    = sig;
    bus.alarm_clr = clr;
    @(posedge clk);
    model_step(sig, clr);
    #1;
    if (bus.period_vld === 1'b1) vld_seen++;
    compare_all();
  endtask

  task automatic apply_reset(input int n, input bit sig);
    rst_n         = 1'b0;
    bus.sig_in    = sig;
    bus.alarm_clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst_n = 1'b1;
  endtask

  // Next rise exactly k cycles after the previous one (k >= 2).
  task automatic rise_after(input int k);
    repeat (k - 1) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

  initial begin
    bit lvl;
    int hold;

    // Table: after reset with sig low; rises at n=0,3,5.
    tbl[0] = '{1'b1, 1'b0, 2'd1, 1, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 2'd1, 1, 0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'd1, 1, 0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 2'd1, 2, 3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 2'd1, 2, 3, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 2'd1, 3, 2, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 2'd1, 3, 2, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 2'd1, 3, 2, 1'b0, 1'b0};

    bus.sig_in    = 1'b0;
    bus.alarm_clr = 1'b0;
    model_reset();

    // Reset held 3 cycles with sig high; first released edge is a rise.
    apply_reset(3, 1'b1);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_cnt", 32'(bus.full_cnt), 32'd0);
    check("rst_period", 32'(bus.period), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    drive(1'b1, 1'b0);
    check("rel_cnt", 32'(bus.full_cnt), 32'd1);
    check("rel_state", 32'(bus.state), 32'd1);
    check("rel_vld", 32'(bus.period_vld), 32'd0);

    // Table-driven vectors
    apply_reset(2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.sig_in    = tbl[i].sig;
      bus.alarm_clr = tbl[i].clr;
      @(posedge clk);
      model_step(tbl[i].sig, tbl[i].clr);
      #1;
      check("tbl_state", 32'(bus.state), 32'(tbl[i].st));
      check("tbl_cnt", 32'(bus.full_cnt), 32'(tbl[i].cnt));
      check("tbl_period", 32'(bus.period), 32'(tbl[i].per));
      check("tbl_vld", 32'(bus.period_vld), 32'(tbl[i].vld));
      check("tbl_timeout", 32'(bus.timeout), 32'(tbl[i].to));
    end

    // Periodic rises 40 apart
    apply_reset(2, 1'b0);
    vld_seen = 0;
    drive(1'b1, 1'b0);
    rise_after(40);
    rise_after(40);
    drive(1'b0, 1'b0);
    check("per40_period", 32'(bus.period), 32'd40);
    check("per40_vld_pulses", 32'(vld_seen), 32'd2);
    check("per40_cnt", 32'(bus.full_cnt), 32'd3);
    check("per40_timeout", 32'(bus.timeout), 32'd0);

    // Timeout path, re-arm, then clear priority
    apply_reset(2, 1'b0);
    drive(1'b1, 1'b0);
    rise_after(30);
    repeat (99) drive(1'b0, 1'b0);
    check("tmo_pre_state", 32'(bus.state), 32'd1);
    check("tmo_pre_flag", 32'(bus.timeout), 32'd0);
    drive(1'b0, 1'b0);
    check("tmo_state", 32'(bus.state), 32'd2);
    check("tmo_flag", 32'(bus.timeout), 32'd1);
    repeat (5) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    check("rearm_state", 32'(bus.state), 32'd1);
    check("rearm_period", 32'(bus.period), 32'd30);
    check("rearm_vld", 32'(bus.period_vld), 32'd0);
    check("rearm_flag_sticky", 32'(bus.timeout), 32'd1);
    drive(1'b0, 1'b1);
    check("clr_flag", 32'(bus.timeout), 32'd0);
    check("clr_state", 32'(bus.state), 32'd1);
    repeat (98) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    check("setwins_flag", 32'(bus.timeout), 32'd1);
    check("setwins_state", 32'(bus.state), 32'd2);
    drive(1'b0, 1'b1);
    check("clr_in_alarm_flag", 32'(bus.timeout), 32'd0);
    check("clr_in_alarm_state", 32'(bus.state), 32'd2);

    // Rise exactly on the timeout cycle wins
    apply_reset(2, 1'b0);
    drive(1'b1, 1'b0);
    rise_after(Tmo);
    check("bound_period", 32'(bus.period), 32'(Tmo));
    check("bound_vld", 32'(bus.period_vld), 32'd1);
    check("bound_timeout", 32'(bus.timeout), 32'd0);
    check("bound_state", 32'(bus.state), 32'd1);

    // Counter saturation, short periods
    apply_reset(2, 1'b0);
    drive(1'b1, 1'b0);
    repeat (19) rise_after(5);
    check("sat_cnt", 32'(bus.full_cnt), 32'(CntMax));
    check("sat_period", 32'(bus.period), 32'd5);
`ifdef LOAD_STORE_WATCH_MINPER_EN
    check("short_set", 32'(bus.short_per), 32'd1);
    drive(1'b0, 1'b1);
    check("short_clr", 32'(bus.short_per), 32'd0);
`endif

    // Randomized traffic with occasional clears and mid-run resets
    apply_reset(2, 1'b0);
    lvl  = 1'b0;
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        lvl  = ~lvl;
        hold = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 130 : 20);
      end
      hold--;
      if ($urandom_range(0, 999) == 0) begin
        apply_reset(1 + $urandom_range(0, 2), lvl);
      end else begin
        drive(lvl, $urandom_range(0, 39) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_watch.md
Name: load_store_watch

Overview:
- Downstream monitor for the load/store volume controller's `sig` output, which is high while the volume sits at its ceiling.
- Detects each rising edge of `sig` (a "full event"), measures the cycle distance between consecutive full events, and counts the events.
- Raises a sticky alarm when no full event arrives within a timeout window.
- Feeds status/telemetry logic; provides a liveness check that the fill/drain cycle keeps oscillating.

Parameters:
- PER_W, 17: width of the period timer and the period output.
- CNT_W, 16: width of the full-event counter.
- TIMEOUT, 60000: maximum cycles between full events before alarm; must be <= 2^PER_W-1.
- MIN_PER, 1000: minimum legal period; used only with the optional feature.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- rst_n, input, 1: synchronous active-low reset, sampled on posedge clk.
- sig_in, input, 1: registered full flag from the load/store stage.
- alarm_clr, input, 1: one-cycle pulse; clears the timeout alarm.
- full_cnt, output, CNT_W: saturating count of full events.
- period, output, PER_W: last measured distance between full events, in cycles.
- period_vld, output, 1: one-cycle pulse when `period` updates.
- timeout, output, 1: sticky alarm flag.
- state, output, 2: current FSM state, for debug.

Behaviour:
- Reset (rst_n=0 at posedge) forces:
  - state=IDLE; full_cnt=0; period=0; period_vld=0; timeout=0.
  - Internal timer=0 and sig_d=0.
  - Reset mid-operation discards any in-flight measurement.
- Edge detect:
  - sig_d <= sig_in every cycle; rise = sig_in & ~sig_d (combinational).
  - A sig_in already high at the first cycle after reset counts as a rise.
- Timer:
  - On rise, timer <= 1.
  - Otherwise, in ARMED or ALARM, timer <= timer+1, saturating at 2^PER_W-1.
  - In IDLE, timer holds 0.
- full_cnt: +1 on each rise; saturates at 2^CNT_W-1 with no wrap.
- FSM states: IDLE=0, ARMED=1, ALARM=2; encoding 3 is unused and recovers to IDLE next cycle.
  - IDLE, rise: go to ARMED. period_vld stays 0, since there is no previous edge.
  - ARMED, rise: period <= timer and period_vld=1 next cycle; stay in ARMED. A rise k cycles after the previous rise yields period=k.
  - ARMED, no rise and timer==TIMEOUT: go to ALARM and set timeout<=1.
  - ALARM, rise: go to ARMED. period is not updated, because the measurement overflowed; period_vld=0; timer <= 1.
- timeout behaviour:
  - Set only by the ARMED->ALARM transition.
  - Cleared by alarm_clr; alarm_clr does not change state.
  - If alarm_clr and the setting transition occur in the same cycle, set wins.
- Simultaneous rise and timer==TIMEOUT in ARMED: the rise wins; period=TIMEOUT, no alarm.
- period_vld is a registered pulse, exactly one cycle wide; back-to-back rises 2 cycles apart give period=2.
- Latency: every output is registered and reflects a rise on the cycle after it is sampled.

Optional Feature:
- Macro: LOAD_STORE_WATCH_MINPER_EN.
- Defined: adds output short_per (1 bit, reset 0).
  - On an ARMED rise with timer < MIN_PER, short_per <= 1, sticky.
  - Cleared by alarm_clr, with the same set-wins priority as timeout.
  - period/period_vld update as normal.
- Undefined: no short_per port and no comparator logic; MIN_PER is unused.

Decomposition:
- Package load_store_watch_pkg:
  - state enum type (IDLE/ARMED/ALARM, 2 bits).
  - Default width constants PER_W_DEF and CNT_W_DEF.
- Sub-module rise_detect holds the sig_d register and the rise output (clk, rst_n, d, rise).
- FSM, timer and counters stay in the top.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with sig_in=1 -> all outputs 0 and state=IDLE. Release -> full_cnt=1, state=ARMED next cycle, period_vld=0.
- Periodic edges (TIMEOUT=100): sig_in rises every 40 cycles, 3 times -> period=40 with period_vld pulsed twice, full_cnt=3, timeout=0.
- Timeout path (TIMEOUT=100): one rise then silence -> state=ALARM and timeout=1 exactly 100 cycles after the rise. Next rise -> ARMED, period unchanged, no period_vld.
- Boundary: second rise exactly 100 cycles after the first (TIMEOUT=100) -> period=100, timeout=0.
- Clear priority: alarm_clr pulsed in ALARM -> timeout=0 next cycle. alarm_clr asserted on the set cycle -> timeout=1.
- Saturation (CNT_W=4): 20 rises -> full_cnt=15. With LOAD_STORE_WATCH_MINPER_EN and MIN_PER=10, rises 5 apart -> short_per=1.
